// File: rtl/div_arbiter.sv
// div_arbiter: two requesters share one restoring divider.
// The FSM moves IDLE -> RUN -> DONE -> IDLE; a zero divisor skips RUN.
// Optional feature macro: DIV_ARB_RR_EN selects round-robin arbitration
// between the requesters. When it is undefined, arbitration is fixed
// priority with req0 winning ties.
module div_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] y0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] y1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         done0,
    output logic         done1,
    output logic [W-1:0] q,
    output logic [W-1:0] r,
    output logic         dz,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] ITER = 4'(W);

    state_t         state_q;
    logic [W:0]     a_q;       // partial remainder
    logic [W-1:0]   wq_q;      // working quotient, holds x at grant
    logic [W-1:0]   y_q;       // captured divisor
    logic [3:0]     cnt_q;     // remaining iterations
    logic           own_q;     // requester that owns the current operation
    logic           gnt0_q, gnt1_q, done0_q, done1_q;
    logic [W-1:0]   q_q, r_q;
    logic           dz_q;
`ifdef DIV_ARB_RR_EN
    logic           ls_q;      // last served requester
`endif

    logic           any_req;
    logic           win1;
    logic [W-1:0]   wx, wy;
    logic [2*W:0]   sh;
    logic [W:0]     a_sh, a_t, a_d;
    logic [W-1:0]   wq_d;

    // Winner selection and the winner's operands
    always_comb begin
        any_req = req0 | req1;
`ifdef DIV_ARB_RR_EN
        // On a tie, serve the requester that was not served last
        win1 = req1 & (~req0 | ~ls_q);
`else
        win1 = req1 & ~req0;
`endif
        wx = win1 ? x1 : x0;
        wy = win1 ? y1 : y0;
    end

    // One restoring-division step on {a, wq}
    always_comb begin
        sh   = {a_q, wq_q} << 1;
        a_sh = sh[2*W:W];
        a_t  = a_sh - {1'b0, y_q};
        if (a_t[W]) begin
            a_d  = a_sh;
            wq_d = {sh[W-1:1], 1'b0};
        end else begin
            a_d  = a_t;
            wq_d = {sh[W-1:1], 1'b1};
        end
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            wq_q    <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            own_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
`ifdef DIV_ARB_RR_EN
            ls_q    <= 1'b1;
`endif
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        a_q    <= '0;
                        wq_q   <= wx;
                        y_q    <= wy;
                        cnt_q  <= ITER;
                        own_q  <= win1;
                        gnt0_q <= ~win1;
                        gnt1_q <= win1;
`ifdef DIV_ARB_RR_EN
                        ls_q   <= win1;
`endif
                        state_q <= (wy == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    wq_q  <= wq_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                        q_q     <= wq_d;
                        r_q     <= a_d[W-1:0];
                        dz_q    <= 1'b0;
                        done0_q <= ~own_q;
                        done1_q <= own_q;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    // Zero divisor: result is published one cycle after the grant
                    if (y_q == '0) begin
                        q_q     <= '1;
                        r_q     <= wq_q;
                        dz_q    <= 1'b1;
                        done0_q <= ~own_q;
                        done1_q <= own_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign q     = q_q;
    assign r     = r_q;
    assign dz    = dz_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter (W=4) with hand-computed expectations.
module tb_div_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic         gnt0, gnt1, done0, done1, dz, busy;
    logic [W-1:0] q, r;

    int checks = 0;
    int failures = 0;

    div_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .q(q), .r(r), .dz(dz), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        step();
        rst = 1'b0;
    endtask

    // Single requester-0 division through the full RUN path
    task automatic run_op0(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] eq, input logic [W-1:0] er);
        req0 = 1'b1; x0 = x; y0 = y;
        step();
        chk({tag, "_gnt0"}, 32'(gnt0), 32'd1);
        req0 = 1'b0;
        repeat (3) step();
        chk({tag, "_early_done"}, 32'(done0), 32'd0);
        step();
        chk({tag, "_done0"}, 32'(done0), 32'd1);
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_dz"}, 32'(dz), 32'd0);
        step();
    endtask

    initial begin
        logic       seen;
        logic       got;
        logic [3:0] exp_seq;
        logic [3:0] got_seq;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_done", 32'({done0, done1}), 32'd0);
        chk("rst_qr", 32'({q, r}), 32'd0);
        chk("rst_dz_busy", 32'({dz, busy}), 32'd0);

        // 13/3 from requester 0
        req0 = 1'b1; x0 = 4'd13; y0 = 4'd3;
        step();
        chk("t1_gnt0", 32'(gnt0), 32'd1);
        chk("t1_gnt1", 32'(gnt1), 32'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen = seen | done0 | done1 | gnt0;
        end
        chk("t1_quiet_run", 32'(seen), 32'd0);
        step();
        chk("t1_done0", 32'(done0), 32'd1);
        chk("t1_done1", 32'(done1), 32'd0);
        chk("t1_q", 32'(q), 32'd4);
        chk("t1_r", 32'(r), 32'd1);
        chk("t1_dz", 32'(dz), 32'd0);
        step();
        chk("t1_done_pulse", 32'(done0), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);
        chk("t1_q_hold", 32'(q), 32'd4);

        // 9/0 from requester 1
        req1 = 1'b1; x1 = 4'd9; y1 = 4'd0;
        step();
        chk("t2_gnt1", 32'(gnt1), 32'd1);
        chk("t2_gnt0", 32'(gnt0), 32'd0);
        chk("t2_no_done_yet", 32'(done1), 32'd0);
        req1 = 1'b0;
        step();
        chk("t2_done1", 32'(done1), 32'd1);
        chk("t2_done0", 32'(done0), 32'd0);
        chk("t2_q", 32'(q), 32'd15);
        chk("t2_r", 32'(r), 32'd9);
        chk("t2_dz", 32'(dz), 32'd1);
        step();
        chk("t2_done_pulse", 32'(done1), 32'd0);

        // Simultaneous requests from reset: 15/4 then 7/2
        do_reset();
        req0 = 1'b1; x0 = 4'd15; y0 = 4'd4;
        req1 = 1'b1; x1 = 4'd7;  y1 = 4'd2;
        step();
        chk("t3_gnt0", 32'(gnt0), 32'd1);
        chk("t3_gnt1_low", 32'(gnt1), 32'd0);
        req0 = 1'b0;
        repeat (4) step();
        chk("t3_done0", 32'(done0), 32'd1);
        chk("t3_q0", 32'(q), 32'd3);
        chk("t3_r0", 32'(r), 32'd3);
        step();
        chk("t3_req1_ignored_in_done", 32'(gnt1), 32'd0);
        step();
        chk("t3_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        repeat (4) step();
        chk("t3_done1", 32'(done1), 32'd1);
        chk("t3_q1", 32'(q), 32'd3);
        chk("t3_r1", 32'(r), 32'd1);

        // Fairness: req1 held, req0 re-raised after each of its grants
        step();
        do_reset();
`ifdef DIV_ARB_RR_EN
        exp_seq = 4'b1010;   // bit k = requester of grant k: 0,1,0,1
`else
        exp_seq = 4'b0000;
`endif
        got_seq = 4'b0000;
        req0 = 1'b1; x0 = 4'd6; y0 = 4'd2;
        req1 = 1'b1; x1 = 4'd5; y1 = 4'd1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                step();
                if (req0 == 1'b0) req0 = 1'b1;
                if (gnt0 | gnt1) begin
                    got = 1'b1;
                    got_seq[k] = gnt1;
                    chk("t4_gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
                    if (gnt0) req0 = 1'b0;
                end
            end
            chk("t4_grant_seen", 32'(got), 32'd1);
        end
        chk("t4_grant_order", 32'(got_seq), 32'(exp_seq));
        req0 = 1'b0; req1 = 1'b0;

        // Reset during the second RUN cycle of 13/3
        do_reset();
        run_op0("t5_pre", 4'd7, 4'd2, 4'd3, 4'd1);   // leave q,r non-zero
        req0 = 1'b1; x0 = 4'd13; y0 = 4'd3;
        step();
        req0 = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt_done", 32'({gnt0, gnt1, done0, done1}), 32'd0);
        chk("t5_rst_qr", 32'({q, r}), 32'd0);
        chk("t5_rst_dz_busy", 32'({dz, busy}), 32'd0);
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | done0 | done1;
        end
        chk("t5_no_done", 32'(seen), 32'd0);
        run_op0("t5_2div9", 4'd2, 4'd9, 4'd0, 4'd2);

        // Boundary operands
        run_op0("t6_15div1", 4'd15, 4'd1, 4'd15, 4'd0);
        run_op0("t6_15div15", 4'd15, 4'd15, 4'd1, 4'd0);
        run_op0("t6_0div5", 4'd0, 4'd5, 4'd0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
